// File: rtl/levinson_q_ctrl_pkg.sv
// Shared types and constants for the Levinson q-recursion controller and datapath.
package levinson_q_ctrl_pkg;

  localparam int DW      = 32;
  localparam int Q_SHIFT = 27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ACC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/levinson_q_ctrl_if.sv
// Handshake and memory-read bundle between the q controller (slave) and its host (master).
interface levinson_q_ctrl_if #(
  parameter int AW = 5
);
  import levinson_q_ctrl_pkg::*;

  logic                 start;
  logic [AW-1:0]        order;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic signed [DW-1:0] q_out;
  logic [AW-1:0]        r_addr;
  logic signed [DW-1:0] r_data;
  logic [AW-1:0]        a_addr;
  logic signed [DW-1:0] a_data;

  modport master (
    output start, order, r_data, a_data,
    input  busy, done, err, q_out, r_addr, a_addr
  );

  modport slave (
    input  start, order, r_data, a_data,
    output busy, done, err, q_out, r_addr, a_addr
  );

endinterface

// File: rtl/levinson_q.sv
// q datapath: selects r[i] or q + (r*a >>> Q_SHIFT)/2, halving rounded symmetrically toward zero.
module levinson_q
  import levinson_q_ctrl_pkg::*;
(
  input  logic                 q_sel,
  input  logic signed [DW-1:0] q_reg,
  input  logic signed [DW-1:0] r_data,
  input  logic signed [DW-1:0] a_data,
  output logic signed [DW-1:0] q_next
);

  logic signed [2*DW-1:0] r_ext;
  logic signed [2*DW-1:0] a_ext;
  logic signed [2*DW-1:0] prod;
  logic signed [2*DW-1:0] scaled;
  logic signed [2*DW-1:0] biased;
  logic signed [2*DW-1:0] halved;
  logic                   unused_hi;

  always_comb begin
    r_ext  = {{DW{r_data[DW-1]}}, r_data};
    a_ext  = {{DW{a_data[DW-1]}}, a_data};
    prod   = r_ext * a_ext;
    scaled = prod >>> Q_SHIFT;
    // adding the sign bit before the shift turns floor-halving into truncation toward zero
    biased = scaled + {{(2*DW-1){1'b0}}, scaled[2*DW-1]};
    halved = biased >>> 1;
    q_next = q_sel ? q_reg + halved[DW-1:0] : r_data;
  end

  assign unused_hi = ^halved[2*DW-1:DW];

endmodule

// File: rtl/levinson_q_ctrl.sv
// Sequencer for one Levinson q recursion over synchronous r/a memories.
// Optional abort input enabled by defining LEVQ_ABORT_EN.
module levinson_q_ctrl
  import levinson_q_ctrl_pkg::*;
#(
  parameter int ORDER_MAX = 16,
  parameter int AW        = 5
) (
  input  logic               clk,
  input  logic               rst,
`ifdef LEVQ_ABORT_EN
  input  logic               abort,
`endif
  levinson_q_ctrl_if.slave   bus
);

  state_e               state_q, state_d;
  logic [AW-1:0]        order_q, order_d;
  logic [AW-1:0]        j_q, j_d;
  logic signed [DW-1:0] q_reg_q, q_reg_d;
  logic signed [DW-1:0] q_out_q, q_out_d;
  logic                 err_q, err_d;
  logic                 q_sel;
  logic signed [DW-1:0] q_next;
  logic                 order_ok;
  logic [AW-1:0]        r_addr;
  logic [AW-1:0]        a_addr;

  levinson_q u_dp (
    .q_sel  (q_sel),
    .q_reg  (q_reg_q),
    .r_data (bus.r_data),
    .a_data (bus.a_data),
    .q_next (q_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      order_q <= '0;
      j_q     <= '0;
      q_reg_q <= '0;
      q_out_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      order_q <= order_d;
      j_q     <= j_d;
      q_reg_q <= q_reg_d;
      q_out_q <= q_out_d;
      err_q   <= err_d;
    end
  end

  assign order_ok = (bus.order != '0) && (int'(bus.order) <= ORDER_MAX);

  always_comb begin
    state_d = state_q;
    order_d = order_q;
    j_d     = j_q;
    q_reg_d = q_reg_q;
    q_out_d = q_out_q;
    err_d   = 1'b0;
    q_sel   = 1'b0;
    r_addr  = '0;
    a_addr  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (order_ok) begin
            order_d = bus.order;
            state_d = ST_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        r_addr  = order_q;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        q_sel   = 1'b0;
        q_reg_d = q_next;
        r_addr  = order_q - AW'(1);
        a_addr  = AW'(1);
        j_d     = AW'(1);
        // q_out is loaded on entry to DONE so it is already valid while done is high
        if (order_q == AW'(1)) begin
          q_out_d = q_next;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        q_sel   = 1'b1;
        q_reg_d = q_next;
        if (j_q < order_q - AW'(1)) begin
          r_addr = order_q - j_q - AW'(1);
          a_addr = j_q + AW'(1);
          j_d    = j_q + AW'(1);
        end else begin
          q_out_d = q_next;
          j_d     = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        q_out_d = q_reg_q;
        j_d     = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef LEVQ_ABORT_EN
    if (abort && (state_q inside {ST_FETCH, ST_LOAD, ST_ACC})) begin
      state_d = ST_IDLE;
      q_out_d = q_out_q;
      j_d     = '0;
      r_addr  = '0;
      a_addr  = '0;
    end
`endif
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.err    = err_q;
  assign bus.q_out  = q_out_q;
  assign bus.r_addr = r_addr;
  assign bus.a_addr = a_addr;

endmodule

// File: tb/tb_levinson_q_ctrl.sv
// Self-checking bench for levinson_q_ctrl: fixed vectors, corner sequences and randomized runs.
module tb_levinson_q_ctrl;

  localparam int ORDER_MAX = 16;
  localparam int AW        = 5;
  localparam longint QDIV  = 64'sd134217728;

  logic clk = 1'b0;
  logic rst;
`ifdef LEVQ_ABORT_EN
  logic abort;
`endif

  levinson_q_ctrl_if #(.AW(AW)) bus ();

  levinson_q_ctrl #(.ORDER_MAX(ORDER_MAX), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef LEVQ_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic signed [31:0] r_mem [32];
  logic signed [31:0] a_mem [32];

  always @(posedge clk) begin
    bus.r_data <= r_mem[bus.r_addr];
    bus.a_data <= a_mem[bus.a_addr];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  ord;
    logic [31:0] r_i;
    logic [31:0] r_im1;
    logic [31:0] a1;
    logic [31:0] exp_q;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // q = r[i] + sum over j of trunc0(floor(r[i-j]*a[j] / 2^27) / 2), modulo 2^32
  function automatic logic [31:0] ref_q(input int ord);
    longint q;
    longint p;
    longint t;
    q = longint'(r_mem[ord]);
    for (int j = 1; j < ord; j++) begin
      p = longint'(r_mem[ord-j]) * longint'(a_mem[j]);
      if (p >= 0) t = p / QDIV;
      else        t = -((-p + QDIV - 1) / QDIV);
      q = q + t / 2;
    end
    return q[31:0];
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 32; k++) begin
      r_mem[k] = $urandom;
      a_mem[k] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) - 32'd128 : $urandom;
    end
  endtask

  task automatic run_op(input logic [4:0] ord, input int ncyc, input int rs1, input int rs2,
                        input int rst_cyc, input int abort_cyc,
                        output int done_cyc, output int n_done, output int err_cyc,
                        output int n_err, output int last_busy, output int n_busy,
                        output logic [4:0] raddr_c1);
    done_cyc = 0; n_done = 0; err_cyc = 0; n_err = 0; last_busy = 0; n_busy = 0;
    raddr_c1 = '0;
    bus.order = ord;
    bus.start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin n_done++; if (done_cyc == 0) done_cyc = c; end
      if (bus.err === 1'b1) begin n_err++; if (err_cyc == 0) err_cyc = c; end
      if (bus.busy === 1'b1) begin n_busy++; last_busy = c; end
      if (c == 1) raddr_c1 = bus.r_addr;
      bus.start = (c == rs1) || (c == rs2);
`ifdef LEVQ_ABORT_EN
      abort = (c == abort_cyc);
`endif
      if (c == rst_cyc) begin
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_qout", bus.q_out, 32'd0);
      end else begin
        rst = 1'b0;
      end
    end
    bus.start = 1'b0;
    rst = 1'b0;
`ifdef LEVQ_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  initial begin
    int done_cyc, n_done, err_cyc, n_err, last_busy, n_busy;
    logic [4:0]  raddr_c1;
    logic [31:0] cur_q;
    logic [31:0] exp_q;
    logic [4:0]  ord;
    bit          valid;

    vecs[0] = '{5'd1,  32'h0100_0000, 32'h0,          32'h0,          32'h0100_0000, 1'b0};
    vecs[1] = '{5'd2,  32'h0000_0010, 32'h0800_0000, 32'h0800_0000, 32'h0400_0010, 1'b0};
    vecs[2] = '{5'd0,  32'h0,          32'h0,          32'h0,          32'h0400_0010, 1'b1};
    vecs[3] = '{5'd17, 32'h0,          32'h0,          32'h0,          32'h0400_0010, 1'b1};
    vecs[4] = '{5'd2,  32'h0,          32'hF800_0000, 32'h0800_0000, 32'hFC00_0000, 1'b0};
    vecs[5] = '{5'd2,  32'h0,          32'h0000_0003, 32'h0800_0000, 32'h0000_0001, 1'b0};
    vecs[6] = '{5'd2,  32'h0,          32'hFFFF_FFFD, 32'h0800_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{5'd2,  32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0005, 1'b0};
    vecs[8] = '{5'd31, 32'h0,          32'h0,          32'h0,          32'h0000_0005, 1'b1};

    for (int k = 0; k < 32; k++) begin r_mem[k] = '0; a_mem[k] = '0; end
    bus.start = 1'b0;
    bus.order = '0;
    rst = 1'b1;
`ifdef LEVQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_busy",   32'(bus.busy), 32'd0);
    chk("reset_done",   32'(bus.done), 32'd0);
    chk("reset_err",    32'(bus.err),  32'd0);
    chk("reset_qout",   bus.q_out,     32'd0);
    chk("reset_r_addr", 32'(bus.r_addr), 32'd0);
    chk("reset_a_addr", 32'(bus.a_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      ord = vecs[v].ord;
      if (!vecs[v].exp_err) begin
        r_mem[ord] = vecs[v].r_i;
        if (ord >= 2) r_mem[ord-1] = vecs[v].r_im1;
        a_mem[1] = vecs[v].a1;
      end
      run_op(ord, vecs[v].exp_err ? 6 : int'(ord) + 6, 0, 0, 0, 0,
             done_cyc, n_done, err_cyc, n_err, last_busy, n_busy, raddr_c1);
      chk("vec_err_cnt",  32'(n_err),    vecs[v].exp_err ? 32'd1 : 32'd0);
      chk("vec_err_cyc",  32'(err_cyc),  vecs[v].exp_err ? 32'd1 : 32'd0);
      chk("vec_done_cnt", 32'(n_done),   vecs[v].exp_err ? 32'd0 : 32'd1);
      chk("vec_done_cyc", 32'(done_cyc), vecs[v].exp_err ? 32'd0 : 32'(ord) + 32'd2);
      chk("vec_busy_cnt", 32'(n_busy),   vecs[v].exp_err ? 32'd0 : 32'(ord) + 32'd2);
      chk("vec_raddr_c1", 32'(raddr_c1), vecs[v].exp_err ? 32'd0 : 32'(ord));
      chk("vec_qout",     bus.q_out,     vecs[v].exp_q);
    end
    cur_q = 32'h0000_0005;

    // start re-pulsed mid-run and in the DONE cycle must both be ignored
    fill_random();
    exp_q = ref_q(16);
    run_op(5'd16, 24, 3, 18, 0, 0, done_cyc, n_done, err_cyc, n_err, last_busy, n_busy, raddr_c1);
    chk("restart_done_cnt", 32'(n_done),    32'd1);
    chk("restart_done_cyc", 32'(done_cyc),  32'd18);
    chk("restart_err_cnt",  32'(n_err),     32'd0);
    chk("restart_last_busy", 32'(last_busy), 32'd18);
    chk("restart_qout",     bus.q_out,      exp_q);

    fill_random();
    run_op(5'd8, 14, 0, 0, 5, 0, done_cyc, n_done, err_cyc, n_err, last_busy, n_busy, raddr_c1);
    chk("rst_run_done_cnt", 32'(n_done), 32'd0);
    chk("rst_run_qout",     bus.q_out,   32'd0);
    cur_q = 32'h0;

`ifdef LEVQ_ABORT_EN
    r_mem[1] = 32'h0000_1234;
    run_op(5'd1, 7, 0, 0, 0, 0, done_cyc, n_done, err_cyc, n_err, last_busy, n_busy, raddr_c1);
    chk("abort_pre_qout", bus.q_out, 32'h0000_1234);
    fill_random();
    run_op(5'd8, 14, 0, 0, 0, 4, done_cyc, n_done, err_cyc, n_err, last_busy, n_busy, raddr_c1);
    chk("abort_done_cnt",  32'(n_done),    32'd0);
    chk("abort_last_busy", 32'(last_busy), 32'd4);
    chk("abort_qout",      bus.q_out,      32'h0000_1234);
    cur_q = 32'h0000_1234;
`endif

    for (int n = 0; n < 24; n++) begin
      fill_random();
      if ($urandom_range(0, 5) == 0) ord = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
      else                           ord = 5'($urandom_range(1, ORDER_MAX));
      valid = (ord >= 5'd1) && (int'(ord) <= ORDER_MAX);
      if (valid) cur_q = ref_q(int'(ord));
      run_op(ord, valid ? int'(ord) + 6 : 6, 0, 0, 0, 0,
             done_cyc, n_done, err_cyc, n_err, last_busy, n_busy, raddr_c1);
      chk("rand_err_cnt",  32'(n_err),    valid ? 32'd0 : 32'd1);
      chk("rand_done_cyc", 32'(done_cyc), valid ? 32'(ord) + 32'd2 : 32'd0);
      chk("rand_qout",     bus.q_out,     cur_q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
